// File: rtl/disp_hole_fill_pkg.sv
// Shared encodings for the disparity post-processing blocks: LR-check flags,
// hole-fill FSM states and the fill-value rule.
package disp_hole_fill_pkg;

    localparam int unsigned MAX_RUN_DEFAULT = 64;

    localparam logic [1:0] FLAG_VALID = 2'b00;
    localparam logic [1:0] FLAG_OCCL  = 2'b10;
    localparam logic [1:0] FLAG_MISM  = 2'b01;

    // One bit per buffered hole: din[16] set means mismatch (01 and 11).
    localparam logic KIND_OCCL = 1'b0;
    localparam logic KIND_MISM = 1'b1;

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [7:0] hole_fill(
        input logic       kind,
        input logic [7:0] left_ref,
        input logic       left_ok,
        input logic [7:0] right_ref,
        input logic       right_ok
    );
        if (kind == KIND_MISM && left_ok && right_ok)
            return (left_ref < right_ref) ? left_ref : right_ref;
        if (left_ok)
            return left_ref;
        if (right_ok)
            return right_ref;
        return '0;
    endfunction

endpackage

// File: rtl/disp_hole_fill_run_buf.sv
// Kind buffer for one run of invalid pixels: one bit per hole, written in
// arrival order and read back in the same order during the flush.
module hole_run_buf #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned CW    = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_wr,
    input  logic          i_wr_bit,
    input  logic          i_rd,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_rd_ptr,
    output logic          o_rd_bit
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_mem;
    logic [CW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_rd_ptr;

    always_ff @(posedge clk) begin
        if (i_wr)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_wr)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_rd)
                r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign o_count  = r_wr_ptr;
    assign o_rd_ptr = r_rd_ptr;
    assign o_rd_bit = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/disp_hole_fill.sv
// Fills occluded/mismatched disparity runs from the valid neighbours on either
// side, stalling upstream while a buffered run is replayed.
module disp_hole_fill
    import disp_hole_fill_pkg::*;
#(
    parameter int unsigned MAX_RUN = MAX_RUN_DEFAULT,
    parameter int unsigned DWIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              en,
    input  logic              valid_in,
    input  logic [DWIDTH+1:0] din,
    input  logic [8:0]        row_len,
    output logic              in_ready,
    output logic [DWIDTH-1:0] dout,
    output logic [1:0]        dout_flag,
    output logic              dout_valid,
    output logic [7:0]        ovf_cnt
);
    localparam int unsigned CW = $clog2(MAX_RUN + 1);

    state_t            r_state, w_state_nxt;
    logic [8:0]        r_col, r_row_len, w_len;
    logic [7:0]        r_left_ref, r_right_ref, w_fill;
    logic              r_left_ok, r_right_ok;
    logic [DWIDTH-1:0] r_close, r_dout, w_emit_word, w_fill_word;
    logic              r_has_close, r_wrap_pend;
    logic [1:0]        r_dout_flag, w_emit_flag;
    logic              r_dout_valid;
    logic [7:0]        r_ovf;
    logic [CW-1:0]     w_run_cnt, w_rd_ptr;
    logic              w_rd_bit, w_act, w_acc, w_pix_ok, w_last, w_run_full;
    logic              w_buf_wr, w_buf_rd, w_buf_clr;
    logic              w_pass_valid, w_close_in, w_force, w_flush_done, w_emit;

    hole_run_buf #(
        .DEPTH (MAX_RUN),
        .CW    (CW)
    ) u_run_buf (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_buf_clr),
        .i_wr     (w_buf_wr),
        .i_wr_bit (din[DWIDTH]),
        .i_rd     (w_buf_rd),
        .o_count  (w_run_cnt),
        .o_rd_ptr (w_rd_ptr),
        .o_rd_bit (w_rd_bit)
    );

    assign in_ready    = (r_state != ST_FLUSH);
    assign w_act       = clken & en;
    assign w_acc       = w_act & valid_in & in_ready;
    assign w_pix_ok    = (din[DWIDTH+1:DWIDTH] == FLAG_VALID);
    // row_len is only honoured on the first pixel of a row
    assign w_len       = (r_col == '0) ? row_len : r_row_len;
    assign w_last      = (r_col == w_len - 9'd1);
    assign w_run_full  = (w_run_cnt == CW'(MAX_RUN - 1));
    assign w_fill      = hole_fill(w_rd_bit, r_left_ref, r_left_ok, r_right_ref, r_right_ok);
    assign w_fill_word = {w_fill, {(DWIDTH-8){1'b0}}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= ST_PASS;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_buf_wr     = 1'b0;
        w_buf_rd     = 1'b0;
        w_buf_clr    = 1'b0;
        w_pass_valid = 1'b0;
        w_close_in   = 1'b0;
        w_force      = 1'b0;
        w_flush_done = 1'b0;
        w_emit       = 1'b0;
        w_emit_word  = r_close;
        w_emit_flag  = FLAG_VALID;
        unique case (r_state)
            ST_PASS: begin
                if (w_acc && w_pix_ok) begin
                    w_pass_valid = 1'b1;
                    w_emit       = 1'b1;
                    w_emit_word  = din[DWIDTH-1:0];
                end else if (w_acc) begin
                    w_buf_wr = 1'b1;
                    if (w_last || w_run_full) begin
                        w_force     = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_acc && w_pix_ok) begin
                    w_close_in  = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end else if (w_acc) begin
                    w_buf_wr = 1'b1;
                    if (w_last || w_run_full) begin
                        w_force     = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_act) begin
                    w_emit = 1'b1;
                    if (w_rd_ptr != w_run_cnt) begin
                        w_buf_rd    = 1'b1;
                        w_emit_word = w_fill_word;
                        w_emit_flag = (w_rd_bit == KIND_MISM) ? FLAG_MISM : FLAG_OCCL;
                    end
                    // without a closing word the flush ends on the last fill
                    if ((w_rd_ptr == w_run_cnt) ||
                        (!r_has_close && (w_rd_ptr == w_run_cnt - 1'b1))) begin
                        w_flush_done = 1'b1;
                        w_buf_clr    = 1'b1;
                        w_state_nxt  = ST_PASS;
                    end
                end
            end
            default: w_state_nxt = ST_PASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col        <= '0;
            r_row_len    <= '0;
            r_left_ref   <= '0;
            r_left_ok    <= 1'b0;
            r_right_ref  <= '0;
            r_right_ok   <= 1'b0;
            r_close      <= '0;
            r_has_close  <= 1'b0;
            r_wrap_pend  <= 1'b0;
            r_dout       <= '0;
            r_dout_flag  <= '0;
            r_dout_valid <= 1'b0;
            r_ovf        <= '0;
        end else begin
            r_dout_valid <= w_emit;
            if (w_emit) begin
                r_dout      <= w_emit_word;
                r_dout_flag <= w_emit_flag;
            end
            if (w_acc) begin
                if (r_col == '0)
                    r_row_len <= row_len;
                r_col <= w_last ? '0 : r_col + 9'd1;
            end
            if (w_pass_valid) begin
                r_left_ref <= din[DWIDTH-1 -: 8];
                r_left_ok  <= 1'b1;
                if (w_last) begin
                    r_left_ok  <= 1'b0;
                    r_right_ok <= 1'b0;
                end
            end
            if (w_close_in) begin
                r_close     <= din[DWIDTH-1:0];
                r_has_close <= 1'b1;
                r_right_ref <= din[DWIDTH-1 -: 8];
                r_right_ok  <= 1'b1;
                r_wrap_pend <= w_last;
            end
            if (w_force) begin
                r_has_close <= 1'b0;
                r_right_ok  <= 1'b0;
                r_wrap_pend <= w_last;
                if (w_run_full && r_ovf != 8'hFF)
                    r_ovf <= r_ovf + 8'd1;
            end
            if (w_flush_done) begin
                if (r_has_close) begin
                    r_left_ref <= r_close[DWIDTH-1 -: 8];
                    r_left_ok  <= 1'b1;
                end
                if (r_wrap_pend) begin
                    r_left_ok  <= 1'b0;
                    r_right_ok <= 1'b0;
                end
                r_has_close <= 1'b0;
                r_wrap_pend <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_flag  = r_dout_flag;
    assign dout_valid = r_dout_valid;
    assign ovf_cnt    = r_ovf;

endmodule

// File: tb/tb_disp_hole_fill.sv
// Directed bench for disp_hole_fill; emitted words are collected as
// {dout_flag, dout} and compared against hand-computed sequences.
module tb_disp_hole_fill;

    logic        clk;
    logic        rst;
    logic        clken;
    logic        en;
    logic        valid_in;
    logic [17:0] din;
    logic [8:0]  row_len;
    logic        in_ready;
    logic [15:0] dout;
    logic [1:0]  dout_flag;
    logic        dout_valid;
    logic [7:0]  ovf_cnt;

    int unsigned n_chk   = 0;
    int unsigned n_pass  = 0;
    int unsigned n_stall = 0;
    logic [17:0] q[$];
    logic [17:0] exp_q[$];

    disp_hole_fill #(
        .MAX_RUN (64),
        .DWIDTH  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .en         (en),
        .valid_in   (valid_in),
        .din        (din),
        .row_len    (row_len),
        .in_ready   (in_ready),
        .dout       (dout),
        .dout_flag  (dout_flag),
        .dout_valid (dout_valid),
        .ovf_cnt    (ovf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (dout_valid === 1'b1)
            q.push_back({dout_flag, dout});
        if (in_ready !== 1'b1)
            n_stall++;
    endtask

    task automatic send(input logic [1:0] f, input logic [7:0] d, input logic [7:0] s);
        int unsigned guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            cycle();
            guard++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        valid_in = 1'b1;
        din      = {f, d, s};
        cycle();
        valid_in = 1'b0;
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, q.size(), exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s[%0d]", tag, i),
                (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        valid_in = 1'b0;
        en       = 1'b1;
        clken    = 1'b1;
        row_len  = 9'd8;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        n_stall = 0;
    endtask

    initial begin
        rst = 1'b0; clken = 1'b1; en = 1'b1; valid_in = 1'b0; din = '0; row_len = 9'd8;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_flag", 32'(dout_flag), 32'h0);
        chk("rst_dvalid", 32'(dout_valid), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_ovf", 32'(ovf_cnt), 32'h0);

        // all-valid row: pass-through with one-cycle latency
        do_reset();
        for (int d = 5; d <= 12; d++) begin
            send(2'b00, 8'(d), 8'(d) ^ 8'hA5);
            chk("pass_word", {14'h0, dout_valid, in_ready, dout_flag, dout},
                {14'h0, 1'b1, 1'b1, 2'b00, 8'(d), 8'(d) ^ 8'hA5});
        end
        cycle();
        chk("pulse_single", 32'(dout_valid), 32'h0);
        chk("pass_stall", n_stall, 0);

        // flag nibble: 0 = valid, 2 = occlusion, 1 = mismatch
        do_reset();
        send(2'b00, 8'd20, 8'h11);
        send(2'b10, 8'hEE, 8'h77);
        send(2'b10, 8'hEE, 8'h77);
        send(2'b00, 8'd30, 8'h22);
        repeat (6) cycle();
        chk("occl_stall", n_stall, 3);
        send(2'b10, 8'hEE, 8'h77);
        send(2'b00, 8'd40, 8'h33);
        repeat (4) cycle();
        exp_q = '{18'h01411, 18'h21400, 18'h21400, 18'h01E22, 18'h21E00, 18'h02833};
        chk_seq("occl");

        do_reset();
        send(2'b00, 8'd20, 8'h01);
        send(2'b01, 8'hEE, 8'h44);
        send(2'b00, 8'd12, 8'h02);
        repeat (4) cycle();
        exp_q = '{18'h01401, 18'h10C00, 18'h00C02};
        chk_seq("mism");
        chk("mism_stall", n_stall, 2);

        // row start with unknown left, row end on mismatch, row_len change mid-row
        do_reset();
        send(2'b10, 8'hEE, 8'h00);
        send(2'b10, 8'hEE, 8'h00);
        send(2'b00, 8'd9, 8'h05);
        row_len = 9'd3;
        for (int d = 12; d <= 15; d++)
            send(2'b00, 8'(d), 8'h00);
        send(2'b01, 8'hEE, 8'h00);
        row_len = 9'd8;
        send(2'b10, 8'hEE, 8'h00);
        send(2'b00, 8'd50, 8'h01);
        repeat (4) cycle();
        exp_q = '{18'h20900, 18'h20900, 18'h00905, 18'h00C00, 18'h00D00,
                  18'h00E00, 18'h00F00, 18'h10F00, 18'h23200, 18'h03201};
        chk_seq("row");

        // run longer than MAX_RUN forces a flush and a fresh run
        do_reset();
        row_len = 9'd511;
        send(2'b00, 8'd7, 8'h00);
        n_stall = 0;
        for (int i = 0; i < 65; i++)
            send(2'b01, 8'hEE, 8'h00);
        chk("ovf_stall", n_stall, 64);
        chk("ovf_cnt", 32'(ovf_cnt), 32'h1);
        send(2'b00, 8'd8, 8'h00);
        repeat (4) cycle();
        exp_q.delete();
        exp_q.push_back(18'h00700);
        for (int i = 0; i < 65; i++)
            exp_q.push_back(18'h10700);
        exp_q.push_back(18'h00800);
        chk_seq("ovf");
        chk("ovf_cnt_end", 32'(ovf_cnt), 32'h1);

        // en / clken low mid-flush freezes emission
        do_reset();
        send(2'b00, 8'd20, 8'h00);
        send(2'b10, 8'hEE, 8'h00);
        send(2'b10, 8'hEE, 8'h00);
        send(2'b00, 8'd30, 8'h00);
        cycle();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                en    = 1'b1;
                clken = 1'b0;
            end
            cycle();
            chk("freeze", {30'h0, dout_valid, in_ready}, 32'h0);
        end
        clken = 1'b1;
        repeat (4) cycle();
        exp_q = '{18'h01400, 18'h21400, 18'h21400, 18'h01E00};
        chk_seq("freeze_seq");

        // reset in the middle of a flush discards the run
        do_reset();
        send(2'b00, 8'd20, 8'h00);
        for (int i = 0; i < 5; i++)
            send(2'b10, 8'hEE, 8'h00);
        send(2'b00, 8'd30, 8'h00);
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("mid_rst", {dout_valid, in_ready, dout_flag, dout, ovf_cnt},
            {1'b0, 1'b1, 2'b00, 16'h0000, 8'h00});
        @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        repeat (10) cycle();
        chk("mid_rst_quiet", q.size(), 0);
        send(2'b00, 8'd33, 8'h44);
        cycle();
        exp_q = '{18'h02144};
        chk_seq("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
